punc_mem_responder: RTL and testbench
=====================================

PUNC_MEM_RESPONDER -- requirements
Module: punc_mem_responder

Interface
REQ-001 Parameter AW, default 8, meaning word-address width of the backing store (2^AW 16-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, meaning wait states inserted before each access (legal range 0..15).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 req_valid  input  1  control unit presents a memory request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store (ST/STI/STR), 0 = load/fetch.
REQ-008 req_addr  input  16  LC3 word address.
REQ-009 req_wdata  input  16  store data.
REQ-010 resp_valid  output  1  one-cycle pulse; response complete.
REQ-011 resp_rdata  output  16  load data, valid only while resp_valid=1.
REQ-012 resp_err  output  1  out-of-range flag, valid only while resp_valid=1.

Function
REQ-013 FSM states IDLE, WAIT, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: on req_valid=1, latch we/addr/wdata; go to WAIT with counter=WAIT_CYCLES, or directly to ACCESS if WAIT_CYCLES=0.
REQ-015 WAIT: decrement counter each cycle; on the cycle the counter reaches 0, go to ACCESS.
REQ-016 ACCESS: commit the write, or issue a synchronous read, of word req_addr; go to RESP.
REQ-017 RESP: resp_valid=1 for exactly one cycle; return to IDLE.
REQ-018 resp_rdata SHALL equal read data for loads and 0x0000 for stores.
REQ-019 Latency: a request accepted at edge T produces resp_valid in cycle T+WAIT_CYCLES+2; the next request is accepted no earlier than the cycle after resp_valid.
REQ-020 req_valid while req_ready=0 SHALL be ignored (no queueing); the requester holds the request until it is accepted.
REQ-021 Latched fields SHALL NOT change after acceptance, regardless of input changes.
REQ-022 A load following a store to the same address SHALL return the stored value.
REQ-023 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.

Reset
REQ-024 While rst=0 at a clock edge: state<=IDLE, counter<=0, latched fields<=0, resp_valid=0, resp_err=0, resp_rdata=0x0000.
REQ-025 req_ready SHALL be 0 while rst=0 and SHALL be 1 in the first cycle after deassertion.
REQ-026 Reset asserted in WAIT or ACCESS SHALL abandon the transaction: no resp_valid, and a write not yet committed in ACCESS is never committed.
REQ-027 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro PUNC_MEM_OOR_CHECK_EN defined: req_addr >= 2^AW SHALL suppress the write, return resp_rdata=0x0000 and resp_err=1, with unchanged latency.
REQ-029 Macro undefined: the array index SHALL be req_addr[AW-1:0] (aliasing/wrap), and resp_err SHALL be tied to 0.

Structure
REQ-030 Package punc_mem_pkg SHALL hold the FSM state encoding, the WAIT_CYCLES counter width (4), and the 16-bit LC3 word width constant.
REQ-031 Sub-module punc_mem_array SHALL implement the 2^AW x 16 single-port array with synchronous read and write.

Verification
REQ-032 Reset, then a store of 0x1234 to 0x0010 accepted at T (WAIT_CYCLES=2) -> resp_valid at T+4 with rdata=0x0000 and err=0; a load of 0x0010 then returns 0x1234.
REQ-033 WAIT_CYCLES=0, load accepted at T -> resp_valid at T+2; req_ready=0 from T+1 until the cycle after resp_valid.
REQ-034 req_addr changed to 0x0020 in WAIT after acceptance of a load of 0x0010 -> data of 0x0010 returned.
REQ-035 rst=0 for one edge during ACCESS of a store of 0xBEEF to 0x0005 -> no resp_valid; a subsequent load of 0x0005 returns the prior value.
REQ-036 With PUNC_MEM_OOR_CHECK_EN, a store to 0x0100 (AW=8) -> resp_err=1, rdata=0x0000, word 0x00 unchanged; without the macro, the same store writes word 0x00 and resp_err=0.
REQ-037 req_valid held high continuously for back-to-back loads -> exactly one response per WAIT_CYCLES+3 cycles, with none dropped or duplicated.

Source files
------------

// File: rtl/punc_mem_pkg.sv
// Shared types and constants for the LC3 memory responder.
package punc_mem_pkg;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;
endpackage

// File: rtl/punc_mem_if.sv
// Request/response bus between the LC3 control unit (master) and the memory responder (slave).
interface punc_mem_if;
  import punc_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/punc_mem_array.sv
// 2^AW x 16 single-port storage with synchronous read and write; contents survive reset.
module punc_mem_array
  import punc_mem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

// File: rtl/punc_mem_responder.sv
// LC3 memory responder: one request at a time, WAIT_CYCLES wait states, then access and a one-cycle response.
// Build option: define PUNC_MEM_OOR_CHECK_EN to flag addresses >= 2^AW instead of wrapping them.
//
// state     | meaning
// ST_IDLE   | ready; latch request on req_valid
// ST_WAIT   | counting down wait states
// ST_ACCESS | array write committed or read issued
// ST_RESP   | resp_valid pulse
module punc_mem_responder
  import punc_mem_pkg::*;
#(
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst,
  punc_mem_if.slave bus
);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              lat_we;
  logic [WORD_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic              accept;
  logic              oor;
  logic              mem_en;
  logic [WORD_W-1:0] mem_rdata;

  assign bus.req_ready = rst & (state == ST_IDLE);
  assign accept        = bus.req_ready & bus.req_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = ST_ACCESS;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // Leave on the cycle the count reaches zero, so WAIT lasts exactly WAIT_CYCLES cycles.
        cnt_nx = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) begin
          cnt_nx   = '0;
          state_nx = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

`ifdef PUNC_MEM_OOR_CHECK_EN
  assign oor = (lat_addr >> AW) != '0;
`else
  logic unused_addr_hi;
  assign oor            = 1'b0;
  assign unused_addr_hi = ^(lat_addr >> AW);
`endif

  // Gating with rst keeps a write pending in ACCESS from landing if reset hits that edge.
  assign mem_en = rst & (state == ST_ACCESS) & ~oor;

  punc_mem_array #(.AW(AW)) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (lat_we),
    .addr  (lat_addr[AW-1:0]),
    .wdata (lat_wdata),
    .rdata (mem_rdata)
  );

  assign bus.resp_valid = rst & (state == ST_RESP);
  assign bus.resp_rdata = (bus.resp_valid && !lat_we && !oor) ? mem_rdata : '0;
`ifdef PUNC_MEM_OOR_CHECK_EN
  assign bus.resp_err   = bus.resp_valid & oor;
`else
  assign bus.resp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_punc_mem_responder.sv
// Self-checking bench for punc_mem_responder: two instances (2 and 0 wait states) against an array model.
module tb_punc_mem_responder;
  import punc_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        v     = 1'b0;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic [15:0] addr  = '0;
  logic [15:0] wdata = '0;

  punc_mem_if bus0();
  punc_mem_if bus1();

  assign bus0.req_valid = v & ~sel;
  assign bus0.req_we    = we;
  assign bus0.req_addr  = addr;
  assign bus0.req_wdata = wdata;
  assign bus1.req_valid = v & sel;
  assign bus1.req_we    = we;
  assign bus1.req_addr  = addr;
  assign bus1.req_wdata = wdata;

  punc_mem_responder #(.AW(8), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  punc_mem_responder #(.AW(8), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  wire        ready_o = sel ? bus1.req_ready  : bus0.req_ready;
  wire        rv_o    = sel ? bus1.resp_valid : bus0.resp_valid;
  wire [15:0] rd_o    = sel ? bus1.resp_rdata : bus0.resp_rdata;
  wire        err_o   = sel ? bus1.resp_err   : bus0.resp_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] mdl [2][256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oor(input logic [15:0] a);
`ifdef PUNC_MEM_OOR_CHECK_EN
    return a >= 16'd256;
`else
    return 1'b0;
`endif
  endfunction

  // One request on the selected instance; inputs are scrambled right after acceptance.
  task automatic xact(input bit s, input bit w, input logic [15:0] a, input logic [15:0] d);
    int n;
    int wc;
    bit exp_err;
    logic [15:0] exp_rd;
    wc      = s ? 0 : 2;
    exp_err = is_oor(a);
    exp_rd  = (w || exp_err) ? 16'h0000 : mdl[s][a % 256];
    sel = s; we = w; addr = a; wdata = d; v = 1'b1;
    n = 0;
    while (!ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("accept_wait", 32'(n), 32'd0);
    @(posedge clk); #1;
    v = 1'b0; addr = a ^ 16'h0030; wdata = ~d; we = ~w;
    n = 0;
    while (!rv_o && n < 50) begin
      check("idle_rdata", 32'(rd_o), 32'h0);
      check("idle_err", 32'(err_o), 32'h0);
      check("busy_ready", 32'(ready_o), 32'h0);
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), 32'(wc + 1));
    check("resp_rdata", 32'(rd_o), 32'(exp_rd));
    check("resp_err", 32'(err_o), 32'(exp_err));
    check("resp_ready", 32'(ready_o), 32'h0);
    @(posedge clk); #1;
    check("pulse_end", 32'(rv_o), 32'h0);
    check("ready_after", 32'(ready_o), 32'h1);
    if (w && !exp_err) mdl[s][a % 256] = d;
  endtask

  initial begin
    int last;
    int nresp;
    logic [15:0] lo;
    logic [15:0] a;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0", 32'(bus0.req_ready), 32'h0);
    check("rst_ready1", 32'(bus1.req_ready), 32'h0);
    check("rst_rv0", 32'(bus0.resp_valid), 32'h0);
    check("rst_rdata0", 32'(bus0.resp_rdata), 32'h0);
    check("rst_err0", 32'(bus0.resp_err), 32'h0);
    rst = 1'b1;
    #1;
    check("post_rst_ready0", 32'(bus0.req_ready), 32'h1);
    check("post_rst_ready1", 32'(bus1.req_ready), 32'h1);

    for (int i = 0; i < 32; i++) begin
      xact(1'b0, 1'b1, 16'(i), 16'($urandom));
      xact(1'b1, 1'b1, 16'(i), 16'($urandom));
    end
    xact(1'b0, 1'b1, 16'h0020, 16'h5555);

    // store then load of the same word
    xact(1'b0, 1'b1, 16'h0010, 16'h1234);
    xact(1'b0, 1'b0, 16'h0010, 16'h0000);

    // zero wait states
    xact(1'b1, 1'b0, 16'h0007, 16'h0000);

    // reset during ACCESS abandons the store
    sel = 1'b0; we = 1'b1; addr = 16'h0005; wdata = 16'hBEEF; v = 1'b1;
    @(posedge clk); #1;
    v = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ready", 32'(bus0.req_ready), 32'h0);
    check("mid_rst_rv", 32'(bus0.resp_valid), 32'h0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready_after", 32'(bus0.req_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abandoned_rv", 32'(bus0.resp_valid), 32'h0);
    end
    xact(1'b0, 1'b0, 16'h0005, 16'h0000);

    // out-of-range / alias store, then word 0
    xact(1'b0, 1'b1, 16'h0100, 16'hAAAA);
    xact(1'b0, 1'b0, 16'h0000, 16'h0000);

    for (int i = 0; i < 60; i++) begin
      lo = 16'($urandom_range(0, 31));
      a  = ($urandom_range(0, 7) == 0) ? (16'h0100 | lo) : lo;
      xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    // back-to-back loads with req_valid held high
    sel = 1'b0; we = 1'b0; addr = 16'h0010; v = 1'b1;
    last = -1;
    nresp = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (i == 40) v = 1'b0;
      if (bus0.resp_valid) begin
        check("b2b_rdata", 32'(bus0.resp_rdata), 32'(mdl[0][16]));
        if (last >= 0) check("b2b_period", 32'(i - last), 32'd5);
        last = i;
        nresp++;
      end
    end
    check("b2b_count", 32'(nresp), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
